clock_gate_ctrl: RTL
====================

// Module: clock_gate_ctrl
// PURPOSE
// - Upstream controller for the gated-clock flop stage: generates its enable_in so the gated
//   clock runs only while work is pending, and stops it after a programmable idle window.
// - Enable is re-timed on the falling edge of clk, so it is stable while clk is high and
//   the downstream (clk && enable) gate is glitch-free.
// - ready_out tells the producer when data may be presented to the gated stage.
// PARAMETERS
// - IDLE_CYCLES  default 8  consecutive idle ON cycles before gate shut-down (>=1)
// - WAKE_CYCLES  default 2  cycles spent in WAKE before ready_out asserts (>=1)
// - CNT_W        default $clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1)  shared counter width (derived)
// PORTS
// - clk           input   1      free-running clock
// - rst_n         input   1      asynchronous, active-low reset
// - activity_in   input   1      work pending for gated stage (sampled on posedge clk)
// - force_on_in   input   1      hold gate open regardless of activity (test/debug)
// - gate_en_out   output  1      enable to downstream gated flop; changes only on negedge clk
// - ready_out     output  1      gated clock running, producer may drive data
// - state_out     output  2      current FSM state (debug), encoding per package
// BEHAVIOUR
// - Reset (async, rst_n=0): state=OFF, counter=0, gate_en_out=0, ready_out=0, state_out=OFF.
//   Deassertion takes effect at the next posedge; reset mid-operation immediately drops
//   gate_en_out (asynchronous clear of the negedge register too).
// - wake = activity_in | force_on_in.
// - FSM (posedge clk):
//   OFF   : gate_req=0. wake -> WAKE, counter<=0.
//   WAKE  : gate_req=1. counter increments; when counter==WAKE_CYCLES-1 -> ON, counter<=0.
//           Activity dropping during WAKE does not abort the wake.
//   ON    : gate_req=1, ready_out=1. wake -> counter<=0; else counter increments;
//           idle with counter==IDLE_CYCLES-1 -> DRAIN.
//   DRAIN : gate_req=1, ready_out=0 (one cycle, lets the last capture complete).
//           wake -> ON (counter<=0); else -> OFF.
// - ready_out is a registered decode of state==ON; no combinational path from inputs.
// - gate_en_out: negedge register of gate_req (state!=OFF). Latency: activity_in high
//   at posedge N (in OFF) -> WAKE after N; gate_en_out rises at negedge after N; first gated
//   rising edge at posedge N+1; ready_out=1 after posedge N+WAKE_CYCLES.
// - Shut-down: last active ON cycle at posedge M -> DRAIN after M+IDLE_CYCLES,
//   OFF after M+IDLE_CYCLES+1, gate_en_out falls at the following negedge.
// - Counter saturates; never wraps. Simultaneous wake and idle-threshold in ON: wake wins.
// - force_on_in held high: FSM stays ON indefinitely, gate_en_out constant 1.
// - gate_en_out never toggles while clk is high (checked by assertion).
// STRUCTURE
// - Package clock_gate_pkg: typedef enum logic [1:0] {CG_OFF=0, CG_WAKE=1, CG_ON=2,
//   CG_DRAIN=3} cg_state_t; default IDLE_CYCLES/WAKE_CYCLES localparams.
// - Sub-module negedge_enable_reg: 1-bit falling-edge flop, async active-low clear,
//   isolates the only negedge logic in the block.
// - Top: always_ff FSM + counter on posedge clk/negedge rst_n; always_comb next-state.
// TESTING
// - Reset: rst_n=0 with activity_in=1 -> gate_en_out=0, ready_out=0, state_out=0 throughout.
// - Wake: defaults, activity_in pulse 1 cycle in OFF -> gate_en_out=1 half-cycle later,
//   ready_out=1 two posedges later, then DRAIN at +8 idle cycles, OFF one cycle later.
// - Re-arm: activity_in=1 during DRAIN -> back to ON, ready_out=1 next cycle, gate_en_out
//   never drops.
// - Idle boundary: activity every 8th cycle (IDLE_CYCLES=8) -> never leaves ON;
//   every 9th cycle -> enters DRAIN once per gap.
// - force_on_in=1 for 100 cycles, activity_in=0 -> state ON, gate_en_out=1 constant.
// - Glitch check: random activity, 10k cycles, assertion gate_en_out stable while clk=1;
//   mid-ON async reset -> gate_en_out=0 within same delta, recovery to OFF.

Source files
------------

// File: rtl/clock_gate_pkg.sv
// Shared types and defaults for the gated-clock enable controller.
package clock_gate_pkg;

    // Controller states; the encoding is visible on state_out for debug.
    typedef enum logic [1:0] {
        CG_OFF   = 2'd0,
        CG_WAKE  = 2'd1,
        CG_ON    = 2'd2,
        CG_DRAIN = 2'd3
    } cg_state_t;

    localparam int CG_IDLE_CYCLES_DEF = 8;
    localparam int CG_WAKE_CYCLES_DEF = 2;

    // Width of the counter shared between the wake and idle windows.
    function automatic int cg_cnt_width(input int idle_cycles, input int wake_cycles);
        int m;
        m = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clock_gate_ctrl_negedge_reg.sv
// Falling-edge enable register. Holding all negedge logic here keeps the
// rest of the block single-edge and makes the glitch-free timing obvious.
module negedge_enable_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Re-time on the falling edge so q is stable for the whole high phase.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else        q <= d;
    end

endmodule

// File: rtl/clock_gate_ctrl.sv
// Gated-clock enable controller: opens the gate while work is pending,
// waits a wake window before declaring ready, and closes the gate after
// a programmable run of idle cycles (with one drain cycle before closing).
module clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = CG_IDLE_CYCLES_DEF,
    parameter int WAKE_CYCLES = CG_WAKE_CYCLES_DEF,
    parameter int CNT_W       = cg_cnt_width(IDLE_CYCLES, WAKE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       activity_in,
    input  logic       force_on_in,
    output logic       gate_en_out,
    output logic       ready_out,
    output logic [1:0] state_out
);

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    cg_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             ready_q;
    logic             wake;
    logic             gate_req;

    assign wake     = activity_in | force_on_in;
    // Counter holds at its ceiling rather than wrapping back to zero.
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    // Gate is requested in every state except OFF.
    assign gate_req = (state_q != CG_OFF);

    // Next-state and counter decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CG_OFF: begin
                if (wake) begin
                    state_d = CG_WAKE;
                    cnt_d   = '0;
                end
            end
            CG_WAKE: begin
                // Wake runs to completion even if activity drops.
                if (cnt_q == WAKE_LAST) begin
                    state_d = CG_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            CG_ON: begin
                // New work restarts the idle window and beats the threshold.
                if (wake) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d = CG_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            CG_DRAIN: begin
                cnt_d   = '0;
                state_d = wake ? CG_ON : CG_OFF;
            end
            default: begin
                state_d = CG_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CG_OFF;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == CG_ON);
        end
    end

    negedge_enable_reg u_en_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gate_req),
        .q     (gate_en_out)
    );

    assign ready_out = ready_q;
    assign state_out = state_q;

endmodule
